// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner with a double-buffered digit register.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCANNER_LZB_EN.
module display_scanner #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [4*NDIG-1:0]                digits,
  input  logic [NDIG-1:0]                  dp,
  input  logic [NDIG-1:0]                  blank,
  input  logic                             load,
  output logic                             load_ack,
  output logic [NDIG-1:0]                  an,
  output logic [6:0]                       seg,
  output logic                             dpo,
  output logic [$clog2(NDIG>1?NDIG:2)-1:0] idx
);

  localparam int IW = $clog2(NDIG > 1 ? NDIG : 2);
  localparam int CW = $clog2(DIV > 1 ? DIV : 2);

  // Handshake: load is a one-cycle strobe with no backpressure (always accepted);
  // load_ack pulses for the one cycle in which the transferred data first becomes active.

  logic [CW-1:0]     cnt;
  logic              tick;
  logic              frame_end;
  logic [4*NDIG-1:0] pend_dig, act_dig;
  logic [NDIG-1:0]   pend_dp, act_dp;
  logic [NDIG-1:0]   pend_blank, act_blank;
  logic              pend_flag;
  logic [3:0]        cur_nib;
  logic              cur_off;

  assign tick      = (cnt == CW'(DIV - 1));
  assign frame_end = tick && (idx == IW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
    end
  end

  // A load on the transfer cycle lands in pending while the old pending moves to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= frame_end && pend_flag;
      if (frame_end && pend_flag) begin
        act_dig   <= pend_dig;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_dig   <= digits;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_flag  <= 1'b1;
      end else if (frame_end) begin
        pend_flag <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

`ifdef DISPLAY_SCANNER_LZB_EN
  logic [NDIG-1:0] lz;

  // Suppression runs from the top digit down until a nonzero nibble or lit dp.
  always_comb begin
    logic lead;
    lz   = '0;
    lead = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (act_dig[4*k +: 4] != 4'h0 || act_dp[k]) lead = 1'b0;
      lz[k] = lead;
    end
  end

  assign cur_off = act_blank[idx] | lz[idx];
`else
  assign cur_off = act_blank[idx];
`endif

  assign cur_nib = act_dig[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= 7'b1111111;
      dpo <= 1'b1;
    end else begin
      an  <= ~(NDIG'(1) << idx);
      seg <= cur_off ? 7'b1111111 : hex7(cur_nib);
      dpo <= cur_off ? 1'b1 : ~act_dp[idx];
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (NDIG=4, DIV=4): directed scenarios then random loads,
// checked every cycle against a frame-arithmetic reference model.
module tb_display_scanner;
  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpo;
  logic [1:0]  idx;

  always #5 clk = ~clk;

  display_scanner #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank), .load(load),
    .load_ack(load_ack), .an(an), .seg(seg), .dpo(dpo), .idx(idx)
  );

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // Reference model: cycles since release, displayed and pending buffers
  int          cyc;
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_blank, p_dp, p_blank;
  bit          p_flag;
  bit          exp_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dpo} while digit k of the given buffer is scanned
  function automatic logic [11:0] disp(input int k, input logic [15:0] dg,
                                       input logic [3:0] dpv, input logic [3:0] bl);
    bit         off;
    bit         allz;
    logic [3:0] nib;
    logic [3:0] an_e;
    off  = bl[k];
    nib  = dg[4*k +: 4];
    allz = 1'b1;
`ifdef DISPLAY_SCANNER_LZB_EN
    for (int j = k; j < NDIG; j++)
      if (dg[4*j +: 4] != 4'h0 || dpv[j]) allz = 1'b0;
    if (k > 0 && allz) off = 1'b1;
`endif
    an_e = 4'b1111;
    an_e[k] = 1'b0;
    return {an_e, off ? 7'b1111111 : hex7(nib), off ? 1'b1 : ~dpv[k]};
  endfunction

  task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    logic [11:0] e;
    digits = d; dp = p; blank = b; load = ld;
    @(posedge clk);
    e = disp((cyc / DIV) % NDIG, m_dig, m_dp, m_blank);
    cyc++;
    exp_ack = 1'b0;
    if (cyc % FRAME == 0 && p_flag) begin
      m_dig = p_dig; m_dp = p_dp; m_blank = p_blank;
      p_flag = 1'b0; exp_ack = 1'b1;
    end
    if (ld) begin
      p_dig = d; p_dp = p; p_blank = b; p_flag = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
    check("idx", idx, (cyc / DIV) % NDIG);
    check("load_ack", load_ack, exp_ack);
    check("an", an, e[11:8]);
    check("seg", seg, e[7:1]);
    check("dpo", dpo, e[0]);
    if (load_ack === 1'b1) ack_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, digits, dp, blank);
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < FRAME && (cyc % FRAME) != phase; i++) cycle(1'b0, digits, dp, blank);
  endtask

  // Reset asserted off the clock edge; outputs must go to reset values immediately
  task automatic do_reset();
    #2;
    rst = 1'b1;
    load = 1'b0;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dpo", dpo, 1'b1);
    check("rst_ack", load_ack, 1'b0);
    check("rst_idx", idx, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    m_dig = '0; m_dp = '0; m_blank = 4'hF;
    p_flag = 1'b0;
  endtask

  initial begin
    do_reset();
    // Idle scan: idx 0..3 every DIV cycles, an trailing by one cycle, all blank
    idle(2 * FRAME + 3);

    // Mid-frame load is held until the wrap, then acknowledged once
    run_until(5);
    ack_seen = 0;
    cycle(1'b1, 16'h8A10, 4'b0100, 4'b0000);
    idle(2 * FRAME);
    check("ack_single_load", ack_seen, 1);

    // Two loads in one frame: latest wins, one ack
    run_until(3);
    ack_seen = 0;
    cycle(1'b1, 16'h1234, 4'b0000, 4'b0000);
    idle(5);
    cycle(1'b1, 16'h5678, 4'b0001, 4'b0000);
    idle(2 * FRAME);
    check("ack_two_loads", ack_seen, 1);

    // Load on the exact boundary cycle
    run_until(5);
    ack_seen = 0;
    cycle(1'b1, 16'h1111, 4'b0000, 4'b0000);
    run_until(FRAME - 1);
    cycle(1'b1, 16'h2222, 4'b1000, 4'b0010);
    check("ack_boundary_first", ack_seen, 1);
    idle(2 * FRAME);
    check("ack_boundary_both", ack_seen, 2);

    // Reset with pending data discards it; display goes blank
    run_until(4);
    cycle(1'b1, 16'h9ABC, 4'b1111, 4'b0000);
    idle(3);
    do_reset();
    ack_seen = 0;
    idle(2 * FRAME);
    check("ack_after_reset", ack_seen, 0);

    // Zeros (leading-zero blanking only in the configured build)
    cycle(1'b1, 16'h0050, 4'b0000, 4'b0000);
    idle(2 * FRAME);
    cycle(1'b1, 16'h0000, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // Random loads, including some that land on boundaries
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0)
        cycle(1'b1, 16'($urandom()), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
      else
        idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
